// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop register sequencer.
package riscv_hwloop_pkg;

  localparam int unsigned HWLP_N_REGS = 2;

  localparam logic [1:0] CSR_SEL_START = 2'd0;
  localparam logic [1:0] CSR_SEL_END   = 2'd1;
  localparam logic [1:0] CSR_SEL_CNT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT
  } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_regs_seq_if.sv
// Setup-command handshake and CSR write bus into the hardware-loop register sequencer.
interface riscv_hwloop_regs_seq_if #(
  parameter int unsigned N_REG_BITS = 1
);
  logic                  setup_valid_i;
  logic                  setup_ready_o;
  logic [N_REG_BITS-1:0] setup_regid_i;
  logic [31:0]           setup_start_i;
  logic [31:0]           setup_end_i;
  logic [31:0]           setup_cnt_i;

  logic                  csr_we_i;
  logic [N_REG_BITS-1:0] csr_regid_i;
  logic [1:0]            csr_sel_i;
  logic [31:0]           csr_wdata_i;

  modport master (
    output setup_valid_i, setup_regid_i, setup_start_i, setup_end_i, setup_cnt_i,
    output csr_we_i, csr_regid_i, csr_sel_i, csr_wdata_i,
    input  setup_ready_o
  );

  modport slave (
    input  setup_valid_i, setup_regid_i, setup_start_i, setup_end_i, setup_cnt_i,
    input  csr_we_i, csr_regid_i, csr_sel_i, csr_wdata_i,
    output setup_ready_o
  );
endinterface

// File: rtl/riscv_hwloop_reg_slice.sv
// One hardware loop: start/end/counter registers plus the IF->ID decrement-in-flight flag.
module riscv_hwloop_reg_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_we,
  input  logic [31:0] commit_start,
  input  logic [31:0] commit_end,
  input  logic [31:0] commit_cnt,
  input  logic        csr_we_start,
  input  logic        csr_we_end,
  input  logic        csr_we_cnt,
  input  logic [31:0] csr_wdata,
  input  logic        dec_req,
  input  logic        id_advance,
  input  logic        flush,
  output logic [31:0] start_addr,
  output logic [31:0] end_addr,
  output logic [31:0] counter,
  output logic        inflight,
  output logic        inflight_next
);

  logic        dec_eff;
  logic [31:0] counter_next;
  logic [31:0] start_next;
  logic [31:0] end_next;

  // A decrement that loses the counter field to a commit or CSR write leaves no trace.
  assign dec_eff = dec_req & ~commit_we & ~csr_we_cnt;

  always_comb begin
    start_next = start_addr;
    if (commit_we)         start_next = commit_start;
    else if (csr_we_start) start_next = csr_wdata;

    end_next = end_addr;
    if (commit_we)       end_next = commit_end;
    else if (csr_we_end) end_next = csr_wdata;

    counter_next = counter;
    if (commit_we)       counter_next = commit_cnt;
    else if (csr_we_cnt) counter_next = csr_wdata;
    else if (dec_eff)    counter_next = (counter == '0) ? '0 : counter - 32'd1;

    inflight_next = inflight;
    if (flush)           inflight_next = 1'b0;
    else if (dec_eff)    inflight_next = 1'b1;
    else if (id_advance) inflight_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr <= '0;
      end_addr   <= '0;
      counter    <= '0;
      inflight   <= 1'b0;
    end else begin
      start_addr <= start_next;
      end_addr   <= end_next;
      counter    <= counter_next;
      inflight   <= inflight_next;
    end
  end

endmodule

// File: rtl/riscv_hwloop_regs_seq.sv
// Hardware-loop register set: sequences setup commands, CSR writes and comparator decrements,
// holding a setup until its loop has no decrement in flight between IF and ID.
module riscv_hwloop_regs_seq
  import riscv_hwloop_pkg::*;
#(
  parameter int unsigned N_REGS     = HWLP_N_REGS,
  parameter int unsigned N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  riscv_hwloop_regs_seq_if.slave bus,
  input  logic [N_REGS-1:0]      hwlp_dec_cnt_i,
  input  logic                   if_advance_i,
  input  logic                   id_advance_i,
  input  logic                   flush_i,
  output logic [N_REGS-1:0][31:0] hwlp_start_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_end_addr_o,
  output logic [N_REGS-1:0][31:0] hwlp_counter_o,
  output logic [N_REGS-1:0]      hwlp_dec_cnt_id_o,
  output logic                   busy_o
);

  hwlp_state_e           state;
  logic [N_REG_BITS-1:0] held_regid;
  logic [31:0]           held_start;
  logic [31:0]           held_end;
  logic [31:0]           held_cnt;

  logic [N_REGS-1:0]     inflight_next;
  logic                  setup_inflight;
  logic                  held_inflight;

  assign bus.setup_ready_o = (state == ST_IDLE);

  // Out-of-range ids match no slice, so they read as "not in flight" and write nothing.
  always_comb begin
    setup_inflight = 1'b0;
    held_inflight  = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (bus.setup_regid_i == N_REG_BITS'(i)) setup_inflight = inflight_next[i];
      if (held_regid == N_REG_BITS'(i))        held_inflight  = inflight_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      held_regid <= '0;
      held_start <= '0;
      held_end   <= '0;
      held_cnt   <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.setup_valid_i) begin
            held_regid <= bus.setup_regid_i;
            held_start <= bus.setup_start_i;
            held_end   <= bus.setup_end_i;
            held_cnt   <= bus.setup_cnt_i;
            state      <= setup_inflight ? ST_DRAIN : ST_COMMIT;
            busy_o     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!held_inflight) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_slice
    logic commit_hit;
    logic csr_hit;

    assign commit_hit = (state == ST_COMMIT) && (held_regid == N_REG_BITS'(i));
    assign csr_hit    = bus.csr_we_i && (bus.csr_regid_i == N_REG_BITS'(i));

    riscv_hwloop_reg_slice u_slice (
      .clk           (clk),
      .rst           (rst),
      .commit_we     (commit_hit),
      .commit_start  (held_start),
      .commit_end    (held_end),
      .commit_cnt    (held_cnt),
      .csr_we_start  (csr_hit && (bus.csr_sel_i == CSR_SEL_START)),
      .csr_we_end    (csr_hit && (bus.csr_sel_i == CSR_SEL_END)),
      .csr_we_cnt    (csr_hit && (bus.csr_sel_i == CSR_SEL_CNT)),
      .csr_wdata     (bus.csr_wdata_i),
      .dec_req       (hwlp_dec_cnt_i[i] & if_advance_i),
      .id_advance    (id_advance_i),
      .flush         (flush_i),
      .start_addr    (hwlp_start_addr_o[i]),
      .end_addr      (hwlp_end_addr_o[i]),
      .counter       (hwlp_counter_o[i]),
      .inflight      (hwlp_dec_cnt_id_o[i]),
      .inflight_next (inflight_next[i])
    );
  end

endmodule

// File: tb/tb_riscv_hwloop_regs_seq.sv
// Directed self-checking bench for riscv_hwloop_regs_seq (regid bus widened to reach out-of-range ids).
module tb_riscv_hwloop_regs_seq;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       hwlp_dec_cnt;
  logic             if_advance;
  logic             id_advance;
  logic             flush;
  logic [1:0][31:0] start_addr;
  logic [1:0][31:0] end_addr;
  logic [1:0][31:0] counter;
  logic [1:0]       dec_cnt_id;
  logic             busy;

  int unsigned assertions = 0;
  int unsigned failures   = 0;

  riscv_hwloop_regs_seq_if #(.N_REG_BITS(2)) bus ();

  riscv_hwloop_regs_seq #(.N_REGS(2), .N_REG_BITS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .hwlp_dec_cnt_i    (hwlp_dec_cnt),
    .if_advance_i      (if_advance),
    .id_advance_i      (id_advance),
    .flush_i           (flush),
    .hwlp_start_addr_o (start_addr),
    .hwlp_end_addr_o   (end_addr),
    .hwlp_counter_o    (counter),
    .hwlp_dec_cnt_id_o (dec_cnt_id),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.setup_valid_i = 1'b0;
    bus.setup_regid_i = '0;
    bus.setup_start_i = '0;
    bus.setup_end_i   = '0;
    bus.setup_cnt_i   = '0;
    bus.csr_we_i      = 1'b0;
    bus.csr_regid_i   = '0;
    bus.csr_sel_i     = '0;
    bus.csr_wdata_i   = '0;
    hwlp_dec_cnt      = '0;
    if_advance        = 1'b0;
    id_advance        = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic drive_setup(input logic [1:0] id, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] c);
    bus.setup_valid_i = 1'b1;
    bus.setup_regid_i = id;
    bus.setup_start_i = s;
    bus.setup_end_i   = e;
    bus.setup_cnt_i   = c;
  endtask

  task automatic drive_csr(input logic [1:0] id, input logic [1:0] sel, input logic [31:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_regid_i = id;
    bus.csr_sel_i   = sel;
    bus.csr_wdata_i = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    assertions++; if (bus.setup_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.setup_ready_o); end
    assertions++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    assertions++; if (start_addr !== '0 || end_addr !== '0) begin failures++; $display("FAIL reset_addr: start %h end %h want 0", start_addr, end_addr); end
    assertions++; if (counter !== '0) begin failures++; $display("FAIL reset_counter: got %h want 0", counter); end
    assertions++; if (dec_cnt_id !== 2'b00) begin failures++; $display("FAIL reset_inflight: got %b want 00", dec_cnt_id); end
  endtask

  task automatic test_setup_basic();
    drive_setup(2'd0, 32'h100, 32'h120, 32'd5);
    assertions++; if (bus.setup_ready_o !== 1'b1) begin failures++; $display("FAIL setup_ready_T: got %b want 1", bus.setup_ready_o); end
    tick();
    bus.setup_valid_i = 1'b0;
    assertions++; if (bus.setup_ready_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL setup_commit_state: ready %b busy %b want 0 1", bus.setup_ready_o, busy); end
    assertions++; if (start_addr[0] !== 32'h0) begin failures++; $display("FAIL setup_early: start0 %h want 0", start_addr[0]); end
    tick();
    assertions++; if (start_addr[0] !== 32'h100 || end_addr[0] !== 32'h120 || counter[0] !== 32'd5) begin
      failures++; $display("FAIL setup_values: %h/%h/%0d want 100/120/5", start_addr[0], end_addr[0], counter[0]); end
    assertions++; if (bus.setup_ready_o !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL setup_return: ready %b busy %b want 1 0", bus.setup_ready_o, busy); end
    assertions++; if (start_addr[1] !== 32'h0 || counter[1] !== 32'h0) begin failures++; $display("FAIL setup_other_loop: %h %h want 0 0", start_addr[1], counter[1]); end
  endtask

  task automatic test_drain();
    hwlp_dec_cnt = 2'b10;
    if_advance   = 1'b1;
    tick();
    hwlp_dec_cnt = '0;
    if_advance   = 1'b0;
    assertions++; if (dec_cnt_id !== 2'b10) begin failures++; $display("FAIL drain_inflight_set: got %b want 10", dec_cnt_id); end
    drive_setup(2'd1, 32'h200, 32'h240, 32'd3);
    tick();
    bus.setup_valid_i = 1'b0;
    assertions++; if (bus.setup_ready_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drain_enter: ready %b busy %b want 0 1", bus.setup_ready_o, busy); end
    tick();
    assertions++; if (bus.setup_ready_o !== 1'b0 || start_addr[1] !== 32'h0) begin failures++; $display("FAIL drain_hold: ready %b start1 %h want 0 0", bus.setup_ready_o, start_addr[1]); end
    id_advance = 1'b1;
    tick();
    id_advance = 1'b0;
    assertions++; if (dec_cnt_id[1] !== 1'b0 || bus.setup_ready_o !== 1'b0) begin failures++; $display("FAIL drain_commit: inflight %b ready %b want 0 0", dec_cnt_id[1], bus.setup_ready_o); end
    // decrement arriving in the commit cycle must lose to the commit
    hwlp_dec_cnt = 2'b10;
    if_advance   = 1'b1;
    tick();
    hwlp_dec_cnt = '0;
    if_advance   = 1'b0;
    assertions++; if (counter[1] !== 32'd3 || start_addr[1] !== 32'h200 || end_addr[1] !== 32'h240) begin
      failures++; $display("FAIL drain_values: %h/%h/%0d want 200/240/3", start_addr[1], end_addr[1], counter[1]); end
    assertions++; if (dec_cnt_id[1] !== 1'b0 || bus.setup_ready_o !== 1'b1) begin failures++; $display("FAIL drain_done: inflight %b ready %b want 0 1", dec_cnt_id[1], bus.setup_ready_o); end
  endtask

  task automatic test_counter_sat();
    drive_csr(2'd0, 2'd2, 32'd1);
    tick();
    bus.csr_we_i = 1'b0;
    assertions++; if (counter[0] !== 32'd1 || start_addr[0] !== 32'h100) begin failures++; $display("FAIL sat_csr: cnt %0d start %h want 1 100", counter[0], start_addr[0]); end
    hwlp_dec_cnt = 2'b01;
    if_advance   = 1'b1;
    tick();
    assertions++; if (counter[0] !== 32'd0 || dec_cnt_id[0] !== 1'b1) begin failures++; $display("FAIL sat_first: cnt %0d inflight %b want 0 1", counter[0], dec_cnt_id[0]); end
    tick();
    assertions++; if (counter[0] !== 32'd0 || dec_cnt_id[0] !== 1'b1) begin failures++; $display("FAIL sat_floor: cnt %0d inflight %b want 0 1", counter[0], dec_cnt_id[0]); end
    if_advance = 1'b0;
    tick();
    assertions++; if (counter[0] !== 32'd0 || dec_cnt_id[0] !== 1'b1) begin failures++; $display("FAIL sat_no_adv: cnt %0d inflight %b want 0 1", counter[0], dec_cnt_id[0]); end
    hwlp_dec_cnt = '0;
    id_advance   = 1'b1;
    tick();
    id_advance = 1'b0;
    assertions++; if (dec_cnt_id[0] !== 1'b0) begin failures++; $display("FAIL sat_clear: inflight %b want 0", dec_cnt_id[0]); end
  endtask

  task automatic test_csr_vs_dec();
    drive_csr(2'd0, 2'd2, 32'd7);
    hwlp_dec_cnt = 2'b01;
    if_advance   = 1'b1;
    tick();
    bus.csr_we_i = 1'b0;
    assertions++; if (counter[0] !== 32'd7 || dec_cnt_id[0] !== 1'b0) begin failures++; $display("FAIL csr_wins: cnt %0d inflight %b want 7 0", counter[0], dec_cnt_id[0]); end
    tick();
    hwlp_dec_cnt = '0;
    if_advance   = 1'b0;
    assertions++; if (counter[0] !== 32'd6 || dec_cnt_id[0] !== 1'b1) begin failures++; $display("FAIL csr_then_dec: cnt %0d inflight %b want 6 1", counter[0], dec_cnt_id[0]); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    assertions++; if (dec_cnt_id !== 2'b00 || counter[0] !== 32'd6) begin failures++; $display("FAIL flush: inflight %b cnt %0d want 00 6", dec_cnt_id, counter[0]); end
    // start-field write does not block a counter decrement on the same loop
    drive_csr(2'd1, 2'd0, 32'h300);
    hwlp_dec_cnt = 2'b10;
    if_advance   = 1'b1;
    tick();
    hwlp_dec_cnt = '0;
    if_advance   = 1'b0;
    drive_csr(2'd1, 2'd3, 32'hdead);
    tick();
    bus.csr_we_i = 1'b0;
    assertions++; if (start_addr[1] !== 32'h300 || end_addr[1] !== 32'h240 || counter[1] !== 32'd2) begin
      failures++; $display("FAIL csr_field: %h/%h/%0d want 300/240/2", start_addr[1], end_addr[1], counter[1]); end
    assertions++; if (dec_cnt_id !== 2'b10) begin failures++; $display("FAIL csr_field_inflight: got %b want 10", dec_cnt_id); end
  endtask

  task automatic test_rst_in_drain();
    drive_setup(2'd1, 32'h400, 32'h480, 32'd9);
    tick();
    bus.setup_valid_i = 1'b0;
    assertions++; if (busy !== 1'b1 || bus.setup_ready_o !== 1'b0) begin failures++; $display("FAIL rstdrain_enter: busy %b ready %b want 1 0", busy, bus.setup_ready_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    assertions++; if (busy !== 1'b0 || bus.setup_ready_o !== 1'b1 || dec_cnt_id !== 2'b00) begin
      failures++; $display("FAIL rstdrain_state: busy %b ready %b inflight %b want 0 1 00", busy, bus.setup_ready_o, dec_cnt_id); end
    assertions++; if (start_addr !== '0 || end_addr !== '0 || counter !== '0) begin failures++; $display("FAIL rstdrain_regs: %h %h %h want 0", start_addr, end_addr, counter); end
    tick();
    tick();
    tick();
    assertions++; if (start_addr[1] !== 32'h0 || counter[1] !== 32'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstdrain_late: start1 %h cnt1 %h busy %b want 0 0 0", start_addr[1], counter[1], busy); end
  endtask

  task automatic test_out_of_range();
    drive_csr(2'd3, 2'd0, 32'h55);
    drive_setup(2'd2, 32'haaa, 32'hbbb, 32'd4);
    tick();
    bus.setup_valid_i = 1'b0;
    bus.csr_we_i      = 1'b0;
    assertions++; if (bus.setup_ready_o !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL oor_commit: ready %b busy %b want 0 1", bus.setup_ready_o, busy); end
    tick();
    assertions++; if (bus.setup_ready_o !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL oor_idle: ready %b busy %b want 1 0", bus.setup_ready_o, busy); end
    assertions++; if (start_addr !== '0 || end_addr !== '0 || counter !== '0) begin failures++; $display("FAIL oor_regs: %h %h %h want 0", start_addr, end_addr, counter); end
  endtask

  task automatic test_back_to_back();
    drive_setup(2'd0, 32'h10, 32'h20, 32'd9);
    tick();
    drive_setup(2'd1, 32'h30, 32'h40, 32'd2);
    tick();
    assertions++; if (bus.setup_ready_o !== 1'b1 || counter[0] !== 32'd9 || start_addr[0] !== 32'h10) begin
      failures++; $display("FAIL b2b_first: ready %b cnt0 %0d start0 %h want 1 9 10", bus.setup_ready_o, counter[0], start_addr[0]); end
    tick();
    bus.setup_valid_i = 1'b0;
    tick();
    assertions++; if (start_addr[1] !== 32'h30 || end_addr[1] !== 32'h40 || counter[1] !== 32'd2 || end_addr[0] !== 32'h20) begin
      failures++; $display("FAIL b2b_second: %h/%h/%0d end0 %h want 30/40/2 20", start_addr[1], end_addr[1], counter[1], end_addr[0]); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_setup_basic();
    test_drain();
    test_counter_sat();
    test_csr_vs_dec();
    test_rst_in_drain();
    test_out_of_range();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
